// File: rtl/bit_population_enumerator.sv
// Streams every WIDTH-bit word with exactly K ones, ascending, one word per
// valid/ready handshake; next word produced by an iterative Gosper step.
module bit_population_enumerator #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [$clog2(WIDTH):0] cnt_i,
  input  logic                   cnt_val_i,
  output logic                   cnt_ready_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   data_val_o,
  input  logic                   data_ready_i,
  output logic                   data_last_o,
  output logic                   err_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    k_q, k_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  // K ones packed at the bottom: first word of the sequence
  function automatic logic [WIDTH-1:0] low_mask(input logic [CW-1:0] k);
    logic [WIDTH:0] one_hot;
    one_hot = (WIDTH+1)'(1) << k;
    return WIDTH'(one_hot - (WIDTH+1)'(1));
  endfunction

  // K ones packed at the top: last word of the sequence
  function automatic logic [WIDTH-1:0] top_mask(input logic [CW-1:0] k);
    logic [CW-1:0] sh;
    sh = CW'(WIDTH) - k;
    return low_mask(k) << sh;
  endfunction

  function automatic logic [CW-1:0] ctz(input logic [WIDTH-1:0] x);
    logic [CW-1:0] n;
    n = CW'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) n = CW'(i);
    end
    return n;
  endfunction

  // Gosper step; shifting by ctz(x)+2 replaces the usual divide by lowest set bit
  function automatic logic [WIDTH-1:0] gosper_next(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] r;
    logic [CW:0]      sh;
    c  = x & (~x + WIDTH'(1));
    r  = x + c;
    sh = (CW+1)'(ctz(x)) + (CW+1)'(2);
    return r | ((r ^ x) >> sh);
  endfunction

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      k_q     <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      k_q     <= k_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] nxt;
    state_d = state_q;
    data_d  = data_q;
    k_d     = k_q;
    last_d  = last_q;
    err_d   = 1'b0;
    nxt     = '0;
    unique case (state_q)
      IDLE: begin
        if (cnt_val_i) begin
          if (cnt_i > CW'(WIDTH)) begin
            err_d = 1'b1;
          end else begin
            k_d     = cnt_i;
            data_d  = low_mask(cnt_i);
            last_d  = (low_mask(cnt_i) == top_mask(cnt_i));
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (data_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            nxt    = gosper_next(data_q);
            data_d = nxt;
            last_d = (nxt == top_mask(k_q));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_ready_o = (state_q == IDLE);
  assign data_val_o  = (state_q == RUN);
  assign data_o      = data_q;
  assign data_last_o = last_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_bit_population_enumerator.sv
// Directed bench for bit_population_enumerator: a WIDTH=4 instance for the
// small hand-checked sequences and a WIDTH=16 instance for reset and K sweep.
module tb_bit_population_enumerator;

  logic clk;

  logic       rst4, cv4, cr4, dv4, drdy4, dl4, e4;
  logic [2:0] c4;
  logic [3:0] d4;

  logic        rst16, cv16, cr16, dv16, drdy16, dl16, e16;
  logic [4:0]  c16;
  logic [15:0] d16;

  int n_tests;
  int n_fail;
  int binom [0:16];
  int cnt;
  bit done;
  logic [15:0] prev;
  logic [3:0]  exp_seq [0:5];

  bit_population_enumerator #(.WIDTH(4)) u_dut4 (
    .clk_i       (clk),
    .arst_i      (rst4),
    .cnt_i       (c4),
    .cnt_val_i   (cv4),
    .cnt_ready_o (cr4),
    .data_o      (d4),
    .data_val_o  (dv4),
    .data_ready_i(drdy4),
    .data_last_o (dl4),
    .err_o       (e4)
  );

  bit_population_enumerator #(.WIDTH(16)) u_dut16 (
    .clk_i       (clk),
    .arst_i      (rst16),
    .cnt_i       (c16),
    .cnt_val_i   (cv16),
    .cnt_ready_o (cr16),
    .data_o      (d16),
    .data_val_o  (dv16),
    .data_ready_i(drdy16),
    .data_last_o (dl16),
    .err_o       (e16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start4(input logic [2:0] k);
    tick();
    c4  = k;
    cv4 = 1'b1;
    tick();
    cv4 = 1'b0;
  endtask

  task automatic start16(input logic [4:0] k);
    tick();
    c16  = k;
    cv16 = 1'b1;
    tick();
    cv16 = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    binom = '{1, 16, 120, 560, 1820, 4368, 8008, 11440, 12870,
              11440, 8008, 4368, 1820, 560, 120, 16, 1};
    exp_seq = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
    rst4 = 1'b1; cv4 = 1'b0; c4 = '0; drdy4 = 1'b0;
    rst16 = 1'b1; cv16 = 1'b0; c16 = '0; drdy16 = 1'b0;
    #12;
    check("rst_data",  {28'd0, d4}, 32'h0);
    check("rst_val",   dv4, 0);
    check("rst_last",  dl4, 0);
    check("rst_err",   e4, 0);
    check("rst_ready", cr4, 1);
    check("rst16_val", dv16, 0);
    rst4 = 1'b0;
    rst16 = 1'b0;

    // 1: K=2 full sequence, constant ready
    drdy4 = 1'b1;
    start4(3'd2);
    for (int i = 0; i < 6; i++) begin
      check("seq_data", {28'd0, d4}, {28'd0, exp_seq[i]});
      check("seq_val",  dv4, 1);
      check("seq_last", dl4, (i == 5) ? 1 : 0);
      check("seq_busy", cr4, 0);
      tick();
    end
    check("seq_end_val",   dv4, 0);
    check("seq_end_ready", cr4, 1);

    // 2: K=0 and K=WIDTH yield one word each
    start4(3'd0);
    check("k0_data", {28'd0, d4}, 32'h0);
    check("k0_val",  dv4, 1);
    check("k0_last", dl4, 1);
    tick();
    check("k0_end", dv4, 0);
    start4(3'd4);
    check("k4_data", {28'd0, d4}, 32'hF);
    check("k4_last", dl4, 1);
    tick();
    check("k4_end", cr4, 1);

    // 3: K > WIDTH rejected
    start4(3'd5);
    check("err_pulse", e4, 1);
    check("err_val",   dv4, 0);
    check("err_ready", cr4, 1);
    tick();
    check("err_clear", e4, 0);
    check("err_val2",  dv4, 0);

    // 4: backpressure on the second word
    drdy4 = 1'b1;
    start4(3'd2);
    check("bp_first", {28'd0, d4}, 32'h3);
    tick();
    drdy4 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("bp_hold", {28'd0, d4}, 32'h5);
      check("bp_val",  dv4, 1);
      tick();
    end
    drdy4 = 1'b1;
    for (int i = 1; i < 6; i++) begin
      check("bp_data", {28'd0, d4}, {28'd0, exp_seq[i]});
      check("bp_last", dl4, (i == 5) ? 1 : 0);
      tick();
    end
    check("bp_end", cr4, 1);

    // 5: async reset mid-sequence, then a fresh request
    drdy16 = 1'b1;
    start16(5'd5);
    check("r16_first", {16'd0, d16}, 32'h001F);
    for (int i = 0; i < 7; i++) tick();
    #3;
    rst16 = 1'b1;
    #1;
    check("ar_data",  {16'd0, d16}, 32'h0);
    check("ar_val",   dv16, 0);
    check("ar_last",  dl16, 0);
    check("ar_ready", cr16, 1);
    tick();
    check("ar_hold_val", dv16, 0);
    check("ar_hold_err", e16, 0);
    #2;
    rst16 = 1'b0;
    start16(5'd3);
    check("ar_k3_data", {16'd0, d16}, 32'h0007);
    check("ar_k3_val",  dv16, 1);
    check("ar_k3_last", dl16, 0);
    while (dv16) begin
      drdy16 = 1'b1;
      tick();
      if (cnt > 1000) break;
    end

    // 6: K sweep with random ready
    for (int k = 0; k <= 16; k++) begin
      drdy16 = 1'b0;
      start16(5'(k));
      cnt  = 0;
      done = 1'b0;
      prev = '0;
      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
        drdy16 = ($urandom_range(15) != 0);
        if (dv16 && drdy16) begin
          check("sweep_pop", $countones(d16), k);
          if (cnt > 0) check("sweep_incr", (d16 > prev) ? 1 : 0, 1);
          prev = d16;
          cnt++;
          if (dl16) done = 1'b1;
        end
        tick();
      end
      check("sweep_done", done, 1);
      check("sweep_len",  cnt, binom[k]);
      check("sweep_idle", cr16, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
